vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_sync_edge.sv | 29 ++
 rtl/vga_rx.sv | 171 +++++++++++++++++
 tb/tb_vga_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 800x525) and the lock-state encoding
// used by the receiver and its sync-edge helper.
package vga_pkg;

    localparam int H_ACTIVE_STD = 640;
    localparam int H_FRONT_STD  = 16;
    localparam int H_SYNC_STD   = 96;
    localparam int H_BACK_STD   = 48;
    localparam int H_TOTAL_STD  = H_ACTIVE_STD + H_FRONT_STD + H_SYNC_STD + H_BACK_STD;

    localparam int V_ACTIVE_STD = 480;
    localparam int V_FRONT_STD  = 10;
    localparam int V_SYNC_STD   = 2;
    localparam int V_BACK_STD   = 33;
    localparam int V_TOTAL_STD  = V_ACTIVE_STD + V_FRONT_STD + V_SYNC_STD + V_BACK_STD;

    localparam int HC_MAX = 1023;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        VERIFY   = 2'd2,
        LOCKED   = 2'd3
    } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// One-stage input register for an active-low sync plus rising-edge detect
// against the value held at the last sample_en cycle.
module vga_sync_edge (
    input  logic i_pixel_clk,
    input  logic i_rst,
    input  logic sync,
    input  logic sample_en,
    output logic sync_s1,
    output logic rise
);

    logic sync_prev;

    // Idle level is high, so reset to 1 to avoid a spurious edge on release.
    always_ff @(posedge i_pixel_clk) begin
        if (i_rst) begin
            sync_s1   <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_s1 <= sync;
            if (sample_en) begin
                sync_prev <= sync_s1;
            end
        end
    end

    assign rise = sync_s1 & ~sync_prev;

endmodule

// File: rtl/vga_rx.sv
// VGA timing recovery: measures line/frame periods, locks onto a stable
// timing and emits pixel coordinates and colour for the active region.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_STD,
    parameter int H_START  = H_BACK_STD,
    parameter int V_ACTIVE = V_ACTIVE_STD,
    parameter int V_START  = V_BACK_STD
) (
    input  logic        i_pixel_clk,
    input  logic        i_rst,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic [3:0]  i_vga_r,
    input  logic [3:0]  i_vga_g,
    input  logic [3:0]  i_vga_b,
    output logic [9:0]  o_coord_x,
    output logic [8:0]  o_coord_y,
    output logic [11:0] o_color,
    output logic        o_pixel_valid,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_error,
    output logic [9:0]  o_h_total,
    output logic [9:0]  o_v_total
);

    localparam logic [9:0] X_FIRST = 10'(H_START);
    localparam logic [9:0] X_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] Y_FIRST = 10'(V_START);
    localparam logic [9:0] Y_END   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0] HC_SAT  = 10'(HC_MAX);

    logic        h_s1, v_s1, le, v_rise, fe;
    logic [11:0] color_s1;
    logic [9:0]  hc, hc_q, vc, vc_q;
    logic [10:0] line_period, frame_period;
    logic        h_mismatch, v_mismatch;
    logic        cap_h, cap_v, err_next;
    logic        active, pix_valid;
    logic [9:0]  x;
    logic [8:0]  y;
    lock_state_t state, state_next;

    vga_sync_edge u_h_edge (
        .i_pixel_clk (i_pixel_clk),
        .i_rst       (i_rst),
        .sync        (i_h_sync),
        .sample_en   (1'b1),
        .sync_s1     (h_s1),
        .rise        (le)
    );

    // v_sync is compared against its value at the previous line edge.
    vga_sync_edge u_v_edge (
        .i_pixel_clk (i_pixel_clk),
        .i_rst       (i_rst),
        .sync        (i_v_sync),
        .sample_en   (le),
        .sync_s1     (v_s1),
        .rise        (v_rise)
    );

    assign fe = le & v_rise;

    always_comb begin
        hc = hc_q;
        vc = vc_q;
        if (le) begin
            hc = '0;
        end else if (hc_q != HC_SAT) begin
            hc = hc_q + 10'd1;
        end
        if (fe) begin
            vc = '0;
        end else if (le && (vc_q != HC_SAT)) begin
            vc = vc_q + 10'd1;
        end
    end

    // hc_q/vc_q hold the previous cycle's count, i.e. the last index of the line/frame.
    assign line_period  = {1'b0, hc_q} + 11'd1;
    assign frame_period = {1'b0, vc_q} + 11'd1;
    assign h_mismatch   = le && (line_period != {1'b0, o_h_total});
    assign v_mismatch   = fe && (frame_period != {1'b0, o_v_total});

    always_comb begin
        state_next = state;
        cap_h      = 1'b0;
        cap_v      = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (fe) begin
                    state_next = MEASURE;
                    cap_h      = 1'b1;
                end
            end
            MEASURE: begin
                if (h_mismatch) begin
                    state_next = UNLOCKED;
                end else if (fe) begin
                    state_next = VERIFY;
                    cap_v      = 1'b1;
                end
            end
            VERIFY: begin
                if (h_mismatch || v_mismatch) begin
                    state_next = UNLOCKED;
                end else if (fe) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (h_mismatch || v_mismatch || (hc == HC_SAT)) begin
                    state_next = UNLOCKED;
                    err_next   = 1'b1;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge i_pixel_clk) begin
        if (i_rst) begin
            state     <= UNLOCKED;
            hc_q      <= '0;
            vc_q      <= '0;
            color_s1  <= '0;
            o_h_total <= '0;
            o_v_total <= '0;
            o_error   <= 1'b0;
        end else begin
            state    <= state_next;
            hc_q     <= hc;
            vc_q     <= vc;
            color_s1 <= {i_vga_r, i_vga_g, i_vga_b};
            o_error  <= err_next;
            if (cap_h) begin
                o_h_total <= line_period[9:0];
            end
            if (cap_v) begin
                o_v_total <= frame_period[9:0];
            end
        end
    end

    assign o_locked  = (state == LOCKED);
    assign active    = (hc >= X_FIRST) && (hc < X_END) && (vc >= Y_FIRST) && (vc < Y_END);
    assign pix_valid = active && (state == LOCKED);
    assign x         = hc - X_FIRST;
    assign y         = 9'(vc - Y_FIRST);

    always_ff @(posedge i_pixel_clk) begin
        if (i_rst) begin
            o_pixel_valid <= 1'b0;
            o_coord_x     <= '0;
            o_coord_y     <= '0;
            o_color       <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_pixel_valid <= pix_valid;
            o_coord_x     <= pix_valid ? x : '0;
            o_coord_y     <= pix_valid ? y : '0;
            o_color       <= pix_valid ? color_s1 : '0;
            o_frame_start <= pix_valid && (x == '0) && (y == '0);
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
// Frame-level bench for vga_rx on a scaled-down timing (28x15) with a
// per-cycle output scoreboard and per-frame lock/error expectations.
module tb_vga_rx;

    localparam int H_ACT = 16;
    localparam int H_ST  = 4;
    localparam int H_SY  = 4;
    localparam int H_TOT = 28;
    localparam int V_ACT = 8;
    localparam int V_ST  = 3;
    localparam int V_SY  = 2;
    localparam int V_TOT = 15;
    localparam int N_ROWS = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic [9:0]  coord_x;
    logic [8:0]  coord_y;
    logic [11:0] color;
    logic        pixel_valid, frame_start, locked, error;
    logic [9:0]  h_total, v_total;

    always #5 clk = ~clk;

    vga_rx #(
        .H_ACTIVE (H_ACT),
        .H_START  (H_ST),
        .V_ACTIVE (V_ACT),
        .V_START  (V_ST)
    ) dut (
        .i_pixel_clk   (clk),
        .i_rst         (rst),
        .i_h_sync      (h_sync),
        .i_v_sync      (v_sync),
        .i_vga_r       (vga_r),
        .i_vga_g       (vga_g),
        .i_vga_b       (vga_b),
        .o_coord_x     (coord_x),
        .o_coord_y     (coord_y),
        .o_color       (color),
        .o_pixel_valid (pixel_valid),
        .o_frame_start (frame_start),
        .o_locked      (locked),
        .o_error       (error),
        .o_h_total     (h_total),
        .o_v_total     (v_total)
    );

    typedef struct packed {
        logic        valid;
        logic        fs;
        logic        lck;
        logic        err;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] col;
    } out_t;

    typedef struct {
        int   tag;
        out_t o;
    } sb_t;

    typedef enum int {K_NORMAL, K_STRETCH, K_HOLD, K_RESET} kind_t;

    typedef struct {
        kind_t kind;
        bit    lock_at_start;
        int    exp_errors;
        bit    check_counts;
    } frame_vec_t;

    sb_t        sb_q[$];
    frame_vec_t rows[N_ROWS];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         valid_cnt, fs_cnt, err_cnt;

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        out_t act;
        out_t e;
        act = {pixel_valid, frame_start, locked, error, coord_x, coord_y, color};
        valid_cnt += int'(pixel_valid);
        fs_cnt    += int'(frame_start);
        err_cnt   += int'(error);
        if (sb_q.size() > 0 && sb_q[0].tag == cyc - 2) begin
            e = sb_q.pop_front().o;
            if (!e.valid) begin
                act.x = '0;
                act.y = '0;
            end
            checkValue("pixel_out", 64'(act), 64'(e));
            if (e.valid && e.x == 10'd15 && e.y == 9'd7) begin
                checkValue("last_pixel_color", 64'(color), 64'(12'hF75));
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic h, input logic v,
                                 input logic [11:0] col, input bit push, input out_t e);
        sb_t s;
        @(posedge clk);
        cyc++;
        #1;
        rst    = rst_v;
        h_sync = h;
        v_sync = v;
        {vga_r, vga_g, vga_b} = col;
        if (push) begin
            s.tag = cyc;
            s.o   = e;
            sb_q.push_back(s);
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkAllZero(input string name);
        checkValue(name, 64'({coord_x, coord_y, color, pixel_valid, frame_start,
                              locked, error, h_total, v_total}), 64'd0);
    endtask

    task automatic driveFrame(input frame_vec_t row);
        bit lock_now;
        lock_now = row.lock_at_start;
        for (int l = 0; l < V_TOT; l++) begin
            int len;
            len = H_TOT;
            if (row.kind == K_STRETCH && l == 5) len = H_TOT + 1;
            if (row.kind == K_HOLD && l == 5) len = 1100 + H_SY;
            for (int c = 0; c < len; c++) begin
                logic       h, v, act, err;
                logic [11:0] col;
                int         xi, yi;
                out_t       e;
                h   = (c < len - H_SY);
                v   = (l < V_TOT - V_SY);
                xi  = c - H_ST;
                yi  = l - V_ST;
                act = (c >= H_ST) && (c < H_ST + H_ACT) && (l >= V_ST) && (l < V_ST + V_ACT);
                col = act ? {xi[3:0], yi[3:0], 4'h5} : 12'($urandom);
                err = 1'b0;
                if ((row.kind == K_STRETCH && l == 6 && c == 0) ||
                    (row.kind == K_HOLD && l == 5 && c == 1023)) begin
                    err      = 1'b1;
                    lock_now = 1'b0;
                end
                if (row.kind == K_RESET && l == 6 && c >= 10 && c < 13) begin
                    lock_now = 1'b0;
                    applyStimulus(1'b1, h, v, col, 1'b0, '0);
                    if (c == 10) begin
                        sb_q.delete();
                    end else begin
                        checkAllZero("reset_mid_frame_outputs");
                    end
                    continue;
                end
                e.valid = lock_now && act;
                e.fs    = e.valid && xi == 0 && yi == 0;
                e.lck   = lock_now;
                e.err   = err;
                e.x     = e.valid ? 10'(xi) : '0;
                e.y     = e.valid ? 9'(yi) : '0;
                e.col   = e.valid ? col : '0;
                applyStimulus(1'b0, h, v, col, 1'b1, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N_ROWS; i++) begin
            rows[i] = '{K_NORMAL, 1'b0, 0, 1'b0};
        end
        rows[3]  = '{K_NORMAL,  1'b1, 0, 1'b1};
        rows[4]  = '{K_STRETCH, 1'b1, 1, 1'b0};
        rows[7]  = '{K_NORMAL,  1'b1, 0, 1'b1};
        rows[8]  = '{K_HOLD,    1'b1, 1, 1'b0};
        rows[11] = '{K_NORMAL,  1'b1, 0, 1'b1};
        rows[12] = '{K_RESET,   1'b1, 0, 1'b0};
        rows[15] = '{K_NORMAL,  1'b1, 0, 1'b1};
        rows[16] = '{K_NORMAL,  1'b1, 0, 1'b1};

        valid_cnt = 0;
        fs_cnt    = 0;
        err_cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 12'($urandom), 1'b0, '0);
            if (i >= 2) checkAllZero("reset_outputs");
        end

        for (int r = 0; r < N_ROWS; r++) begin
            valid_cnt = 0;
            fs_cnt    = 0;
            err_cnt   = 0;
            driveFrame(rows[r]);
            checkValue($sformatf("frame%0d_error_pulses", r), 64'(err_cnt), 64'(rows[r].exp_errors));
            if (rows[r].check_counts) begin
                checkValue($sformatf("frame%0d_valid_count", r), 64'(valid_cnt), 64'(H_ACT * V_ACT));
                checkValue($sformatf("frame%0d_frame_starts", r), 64'(fs_cnt), 64'd1);
                checkValue($sformatf("frame%0d_h_total", r), 64'(h_total), 64'(H_TOT));
                checkValue($sformatf("frame%0d_v_total", r), 64'(v_total), 64'(V_TOT));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
